// File: rtl/serial_buffer_ctrl.sv
// Serial word receiver feeding an internal RAM, with a send-triggered serial replay of the whole buffer.
// Frames: 1 start bit, DATA_W data bits LSB first, 1 stop bit; CLKS_PER_BIT clocks per bit.
module serial_buffer_ctrl #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic            sysclk,
    input  logic            reset,
    input  logic            write,
    input  logic            send,
    input  logic            serialIn,
    output logic            out_fin,
    output logic            busy,
    output logic            done,
    output logic [ADDR_W:0] count,
    output logic            overflow,
    output logic            frm_err
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CW    = ADDR_W + 1;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CPB_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [CW-1:0]    FULL     = CW'(DEPTH);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] TX_IDLE  = 3'd0;
    localparam logic [2:0] TX_FETCH = 3'd1;
    localparam logic [2:0] TX_START = 3'd2;
    localparam logic [2:0] TX_DATA  = 3'd3;
    localparam logic [2:0] TX_STOP  = 3'd4;

    logic [2:0]        sync_q, sync_d;
    logic              rx_s, rx_prev;

    logic [1:0]        rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic              rx_store_c, rx_ferr_c, rx_ovf_c;

    logic [1:0]        send_q, send_d;
    logic              req_c;
    logic [2:0]        tx_state_q, tx_state_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              out_fin_q, out_fin_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tx_clr_c;

    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              frm_err_q, frm_err_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Two synchroniser stages plus one history stage for falling-edge detection.
    assign sync_d  = {sync_q[1:0], serialIn};
    assign rx_s    = sync_q[1];
    assign rx_prev = sync_q[2];

    // Receive FSM; held idle whenever playback owns the buffer.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_store_c = 1'b0;
        rx_ferr_c  = 1'b0;
        rx_ovf_c   = 1'b0;
        if (busy_q) begin
            rx_state_d = RX_IDLE;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state_d = RX_START;
                        rx_cnt_d   = '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_M1) begin
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_d = rx_cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == CPB_M1) begin
                        rx_cnt_d   = '0;
                        rx_shift_d = {rx_s, rx_shift_q[DATA_W-1:1]};
                        if (rx_bit_q == LAST_BIT) begin
                            rx_state_d = RX_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + BIT_W'(1);
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == CPB_M1) begin
                        rx_state_d = RX_IDLE;
                        if (!rx_s) begin
                            rx_ferr_c = 1'b1;
                        end else if (write) begin
                            if (count_q == FULL) begin
                                rx_ovf_c = 1'b1;
                            end else begin
                                rx_store_c = 1'b1;
                            end
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + CNT_W'(1);
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    // Transmit FSM: one fetch cycle per word, then start/data/stop.
    always_comb begin
        send_d     = {send_q[0], send};
        req_c      = send_q[0] && !send_q[1];
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        rd_ptr_d   = rd_ptr_q;
        out_fin_d  = out_fin_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_clr_c   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                out_fin_d = 1'b1;
                if (req_c && (count_q != '0)) begin
                    tx_state_d = TX_FETCH;
                    busy_d     = 1'b1;
                    rd_ptr_d   = '0;
                end
            end
            TX_FETCH: begin
                tx_state_d = TX_START;
                tx_cnt_d   = '0;
                out_fin_d  = 1'b0;
            end
            TX_START: begin
                if (tx_cnt_q == CPB_M1) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    out_fin_d  = rd_data_q[0];
                    tx_shift_d = {1'b0, rd_data_q[DATA_W-1:1]};
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CPB_M1) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = TX_STOP;
                        out_fin_d  = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + BIT_W'(1);
                        out_fin_d  = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[DATA_W-1:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CPB_M1) begin
                    if ((CW'(rd_ptr_q) + CW'(1)) < count_q) begin
                        rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                        tx_state_d = TX_FETCH;
                    end else begin
                        tx_state_d = TX_IDLE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        tx_clr_c   = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                busy_d     = 1'b0;
                out_fin_d  = 1'b1;
            end
        endcase
    end

    // Fill count and sticky error flags; store and clear never coincide since RX idles while busy.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q | rx_ovf_c;
        frm_err_d  = frm_err_q | rx_ferr_c;
        if (tx_clr_c) begin
            count_d = '0;
        end else if (rx_store_c) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            send_q     <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            rd_ptr_q   <= '0;
            out_fin_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            send_q     <= send_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            rd_ptr_q   <= rd_ptr_d;
            out_fin_q  <= out_fin_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            frm_err_q  <= frm_err_d;
        end
    end

    // Buffer RAM: contents survive reset, read has one cycle of latency.
    always_ff @(posedge sysclk) begin
        if (rx_store_c) begin
            mem[count_q[ADDR_W-1:0]] <= rx_shift_q;
        end
        rd_data_q <= mem[rd_ptr_q];
    end

    assign out_fin  = out_fin_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign frm_err  = frm_err_q;

endmodule

// File: doc/serial_buffer_ctrl.md
Name: serial_buffer_ctrl

Overview:
Parametrised successor to the serial-in/RAM/serial-out control path. It receives framed serial words on serialIn and stores them in an internal RAM of depth 2**ADDR_W. On a send request it replays every stored word, in order, as framed serial data on out_fin. Adds generic word width, baud divider, fill count, framing-error and overflow detection, and a busy/done handshake.

Parameters:
DATA_W, 16, bits per word (2..32)
ADDR_W, 8, RAM address width; depth = 2**ADDR_W
CLKS_PER_BIT, 4, sysclk cycles per serial bit (>=3)

Ports:
sysclk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
write  input  1  level; 1 = store received words into RAM
send  input  1  rising edge requests playback of buffer
serialIn  input  1  serial receive line, idle high
out_fin  output  1  serial transmit line, idle high
busy  output  1  1 while playback is in progress
done  output  1  one-cycle pulse after last stop bit
count  output  ADDR_W+1  number of words stored
overflow  output  1  sticky: a word was dropped because RAM was full
frm_err  output  1  sticky: a received stop bit sampled 0

Behaviour:
- Reset (reset=0, asynchronous): out_fin=1, busy=0, done=0, count=0, overflow=0, frm_err=0. RX and TX return to IDLE. RAM contents are undefined.
- Frame format: 1 start bit (0), DATA_W data bits LSB first, 1 stop bit (1). Each bit lasts CLKS_PER_BIT cycles.
- serialIn passes through a 2-flop synchroniser before any use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on a synchronised falling edge.
  - In START, sample at CLKS_PER_BIT/2. If the sample is 1, treat it as a glitch and return to IDLE. Otherwise go to DATA.
  - In DATA, sample every CLKS_PER_BIT cycles until DATA_W bits are shifted in, then go to STOP.
  - In STOP, take one sample. If it is 1 and the word is accepted, write it to RAM[count] and increment count on the same cycle. If it is 0, discard the word and set frm_err. Return to IDLE either way.
- Word acceptance requires write=1 at the stop-bit sample and busy=0.
  - If write=0, the word is silently discarded.
  - If count==2**ADDR_W, the word is discarded and overflow is set. count saturates.
- While busy=1, the RX FSM is held in IDLE and frames are ignored. frm_err and overflow do not change.
- Send request: register send; a request is the condition send=1 and previous send=0.
  - A request with busy=0 and count>0 starts playback.
  - A request while busy=1 is ignored. A request with count==0 is ignored and produces no done pulse.
- TX FSM states: IDLE, FETCH, START, DATA, STOP.
  - The request-detect cycle sets busy=1 and rd_ptr=0 and enters FETCH.
  - FETCH lasts 1 cycle (synchronous RAM read, 1-cycle latency). out_fin stays 1 during FETCH.
  - START, DATA and STOP then drive the frame. out_fin is registered.
  - After STOP: if rd_ptr+1<count, increment rd_ptr and go to FETCH. This leaves 1 idle-high cycle between frames.
  - Otherwise return to IDLE. On that transition: busy=0, done=1 for exactly one cycle, count=0 (buffer consumed).
  - overflow and frm_err are not cleared by playback.
- Latency: the first start bit appears on out_fin 2 cycles after the cycle send is first sampled high.
- Playback time: count*((DATA_W+2)*CLKS_PER_BIT+1) cycles.
- write is ignored by TX. Changing write mid-frame affects only the stop-bit acceptance decision.
- Reset asserted mid-frame or mid-playback aborts immediately to reset values. No done pulse is produced.

Test Plan:
1. Defaults, write=1; send 0xA5C3 then 0x0001 on serialIn → count=2, overflow=0, frm_err=0. Pulse send → out_fin low 2 cycles later; frames carry 0xA5C3 then 0x0001, LSB first, 4 cycles/bit; done pulses once after 2*73 cycles; count=0, busy=0.
2. write=0, send 0x1234 → count stays 0. Then pulse send → busy stays 0, no done, out_fin stays 1.
3. ADDR_W=2, write=1, send 5 words 0x0001..0x0005 → count=4, overflow=1. Playback emits 0x0001..0x0004 only.
4. Frame 0xFFFF with stop bit forced 0 → frm_err=1, count unchanged. A following valid frame 0x00FF is stored, and frm_err stays 1.
5. During playback of 3 words: pulse send again and drive a valid frame on serialIn → no restart, exactly 3 frames out, one done, count=0 afterwards.
6. Assert reset (reset=0) during word 2 of playback → out_fin=1 and busy=0 immediately; count=0; no done pulse; 1-cycle pulse on serialIn line is rejected as glitch after release.
